// File: rtl/spi_slave_mode.sv
// SPI slave with configurable width, CPOL/CPHA and bit order, synchronised into clk.
// Provides ready/valid TX and RX handshakes with overrun/underrun pulses.
module spi_slave_mode #(
    parameter int   WIDTH       = 8,
    parameter logic CPOL        = 1'b0,
    parameter logic CPHA        = 1'b0,
    parameter logic MSB_FIRST   = 1'b1,
    parameter int   SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_clk,
    input  logic             spi_cs_n,
    input  logic             mosi,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             miso,
    output logic             miso_oe,
    output logic             busy,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             overrun,
    output logic             underrun
);
    localparam int         CW        = $clog2(WIDTH);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync, r_fill;
    logic                   r_armed, r_need_load;
    logic [0:0]             r_state;
    logic [CW-1:0]          r_count;
    logic [WIDTH-1:0]       r_tx_shift, r_rx_shift, r_hold, r_rx_data;
    logic                   r_tx_ready, r_miso, r_oe, r_busy, r_rx_valid, r_overrun, r_underrun;

    logic             w_rise, w_fall, w_lead, w_trail, w_sample, w_shift;
    logic             w_cs_n, w_mosi, w_start, w_stop, w_samp, w_shft;
    logic             w_reload, w_hold_bit, w_copy, w_word_done, w_accept, w_out_next;
    logic [WIDTH-1:0] w_load_val, w_tx_shifted, w_rx_next, w_tx_next;

    // Input synchronisers; r_fill marks when the CS chain holds real pin samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= {SYNC_STAGES{CPOL}};
            r_cs_sync   <= {SYNC_STAGES{1'b1}};
            r_mosi_sync <= {SYNC_STAGES{1'b0}};
            r_fill      <= {SYNC_STAGES{1'b0}};
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_fill      <= {r_fill[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_rise   = r_sclk_sync[SYNC_STAGES-2] & ~r_sclk_sync[SYNC_STAGES-1];
    assign w_fall   = ~r_sclk_sync[SYNC_STAGES-2] & r_sclk_sync[SYNC_STAGES-1];
    assign w_lead   = CPOL ? w_fall : w_rise;
    assign w_trail  = CPOL ? w_rise : w_fall;
    assign w_sample = CPHA ? w_trail : w_lead;
    assign w_shift  = CPHA ? w_lead : w_trail;
    assign w_cs_n   = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi   = r_mosi_sync[SYNC_STAGES-1];

    // A frame may only start once CS has genuinely been seen high since reset.
    assign w_start     = (r_state == ST_IDLE) && r_armed && !w_cs_n;
    assign w_stop      = (r_state == ST_ACTIVE) && w_cs_n;
    assign w_samp      = (r_state == ST_ACTIVE) && !w_cs_n && w_sample;
    assign w_shft      = (r_state == ST_ACTIVE) && !w_cs_n && w_shift;
    assign w_reload    = w_shft && r_need_load;
    assign w_hold_bit  = w_shft && !r_need_load && CPHA && (r_count == {CW{1'b0}});
    assign w_copy      = w_start || w_reload;
    assign w_load_val  = r_tx_ready ? {WIDTH{1'b0}} : r_hold;
    assign w_word_done = w_samp && (r_count == CW'(WIDTH - 1));
    assign w_accept    = r_rx_valid && rx_ready;

    assign w_tx_shifted = MSB_FIRST ? {r_tx_shift[WIDTH-2:0], 1'b0} : {1'b0, r_tx_shift[WIDTH-1:1]};
    assign w_rx_next    = MSB_FIRST ? {r_rx_shift[WIDTH-2:0], w_mosi} : {w_mosi, r_rx_shift[WIDTH-1:1]};

    // Next TX shift register contents: reload, shift, or hold.
    always_comb begin
        w_tx_next = r_tx_shift;
        if (w_copy) begin
            w_tx_next = w_load_val;
        end else if (w_shft && !w_hold_bit) begin
            w_tx_next = w_tx_shifted;
        end else begin
            w_tx_next = r_tx_shift;
        end
    end

    assign w_out_next = MSB_FIRST ? w_tx_next[WIDTH-1] : w_tx_next[0];

    // TX holding register; a same-cycle copy takes the old contents first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold     <= {WIDTH{1'b0}};
            r_tx_ready <= 1'b1;
        end else if (tx_valid && r_tx_ready) begin
            r_hold     <= tx_data;
            r_tx_ready <= 1'b0;
        end else if (w_copy) begin
            r_tx_ready <= 1'b1;
        end
    end

    // Frame FSM, bit counter and shift registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_armed     <= 1'b0;
            r_count     <= {CW{1'b0}};
            r_need_load <= 1'b0;
            r_tx_shift  <= {WIDTH{1'b0}};
            r_rx_shift  <= {WIDTH{1'b0}};
            r_busy      <= 1'b0;
            r_oe        <= 1'b0;
            r_miso      <= 1'b0;
        end else begin
            r_armed    <= r_armed | (r_fill[SYNC_STAGES-1] & w_cs_n);
            r_tx_shift <= w_tx_next;
            if (w_start) begin
                r_state     <= ST_ACTIVE;
                r_busy      <= 1'b1;
                r_oe        <= 1'b1;
                r_count     <= {CW{1'b0}};
                r_need_load <= 1'b0;
                r_rx_shift  <= {WIDTH{1'b0}};
                r_miso      <= w_out_next;
            end else if (w_stop) begin
                r_state     <= ST_IDLE;
                r_busy      <= 1'b0;
                r_oe        <= 1'b0;
                r_count     <= {CW{1'b0}};
                r_need_load <= 1'b0;
                r_miso      <= 1'b0;
            end else begin
                if (w_samp) begin
                    r_rx_shift <= w_rx_next;
                    r_count    <= w_word_done ? {CW{1'b0}} : r_count + CW'(1);
                    if (w_word_done) begin
                        r_need_load <= 1'b1;
                    end
                end
                if (w_shft) begin
                    r_miso <= w_out_next;
                    if (w_reload) begin
                        r_need_load <= 1'b0;
                    end
                end
            end
        end
    end

    // RX output word, handshake and status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_data  <= {WIDTH{1'b0}};
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_overrun  <= w_word_done && r_rx_valid && !w_accept;
            r_underrun <= w_copy && r_tx_ready;
            if (w_word_done && (!r_rx_valid || w_accept)) begin
                r_rx_data  <= w_rx_next;
                r_rx_valid <= 1'b1;
            end else if (w_accept) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign tx_ready = r_tx_ready;
    assign miso     = r_miso;
    assign miso_oe  = r_oe;
    assign busy     = r_busy;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign overrun  = r_overrun;
    assign underrun = r_underrun;
endmodule

// File: doc/spi_slave_mode.md
Name: spi_slave_mode

Overview:
- Parametrised successor to the fixed 8-bit, mode-0 SPI slave used on the cart MCU link.
- Adds configurable word width, CPOL/CPHA mode and bit order.
- Adds chip-select framing, back-to-back words within one frame, and ready/valid handshakes on both the TX and RX sides with overrun/underrun flags.
- Sits between the external SPI master pins and the cart register/command logic, all in the `clk` domain.

Parameters:
- WIDTH, 8: bits per SPI word (2..32).
- CPOL, 0: idle level of spi_clk.
- CPHA, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- MSB_FIRST, 1: 1 = MSB shifted first; 0 = LSB first.
- SYNC_STAGES, 2: synchroniser flops on spi_clk, spi_cs_n and mosi (>= 2).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- spi_clk  in  1  SPI serial clock from the master (asynchronous).
- spi_cs_n  in  1  active-low chip select (asynchronous).
- mosi  in  1  serial data from the master.
- tx_data  in  WIDTH  next word to transmit.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  TX holding register is empty.
- miso  out  1  serial data to the master.
- miso_oe  out  1  tristate enable for miso; high only while selected.
- busy  out  1  frame in progress (synchronised CS asserted).
- rx_data  out  WIDTH  last completed received word.
- rx_valid  out  1  rx_data holds an unconsumed word.
- rx_ready  in  1  consumer accepts rx_data.
- overrun  out  1  one-cycle pulse: word completed while rx_valid was still high.
- underrun  out  1  one-cycle pulse: word started with TX holding register empty.

Behaviour:
- Reset values: tx_ready=1, miso=0, miso_oe=0, busy=0, rx_data=0, rx_valid=0, overrun=0, underrun=0. State is IDLE, bit counter is 0, TX holding register is empty. All synchroniser flops reset to the inactive level: cs_n=1, spi_clk=CPOL, mosi=0.
- Input timing: all three pins pass through SYNC_STAGES flops. Edges are detected on the last two stages of spi_clk. Master spi_clk half-period must be >= SYNC_STAGES+2 clk cycles; behaviour below that rate is undefined.
- Edge definitions:
  - Leading edge = rising when CPOL=0, falling when CPOL=1. Trailing edge is the opposite.
  - Sample edge = leading when CPHA=0, trailing when CPHA=1. Shift edge is the other one.
- TX holding register: tx_valid && tx_ready loads tx_data and drops tx_ready. It empties (tx_ready=1 next cycle) when its contents are copied into the shift register.
- FSM:
  - IDLE -> ACTIVE on synchronised CS falling. busy=1 and miso_oe=1 in that same cycle. Shift register loads from the holding register; if the holding register is empty it loads 0 and underrun pulses. Bit counter is cleared.
  - ACTIVE, sample edge:
    - mosi (synchronised) shifts into the RX shift register, at the LSB end if MSB_FIRST=1, otherwise at the MSB end. Counter increments.
    - When the counter reaches WIDTH, the counter wraps to 0 and the word completes.
    - If rx_valid=0, the word is written to rx_data and rx_valid=1 on the next cycle.
    - If rx_valid=1, the word is dropped, rx_data is unchanged, and overrun pulses.
  - ACTIVE, shift edge: miso advances to the next bit.
    - CPHA=0: the shift edge that follows a completed word reloads the shift register instead of shifting (same underrun rule as frame start).
    - CPHA=1: the first shift edge of each word loads/presents the first bit instead of shifting.
  - ACTIVE -> IDLE on synchronised CS rising. A partial word is discarded: no rx_valid, no overrun. Counter clears; busy=0, miso_oe=0, miso=0 next cycle. The holding register is preserved.
- miso: registered, equal to the current output bit (MSB or LSB per MSB_FIRST). With CPHA=0 the first bit is valid from the CS-fall cycle.
- RX handshake: rx_valid && rx_ready clears rx_valid next cycle. If a word completes in the same cycle as this acceptance, the new word is stored and rx_valid stays 1; no overrun.
- TX handshake: a TX load and a copy-to-shift in the same cycle — the copy takes the old contents and the new word is stored; tx_ready stays 0.
- Async rst asserted mid-frame: all outputs return to reset values immediately. After release the block waits in IDLE; it only starts a frame on a CS rising-then-falling sequence, never on CS already low.

Test Plan:
- Mode 0, WIDTH=8, spi half-period 4 clk cycles, tx_data=8'h59 preloaded, master sends 8'hA3 MSB first -> miso bits 0,1,0,1,1,0,0,1; rx_data=8'hA3, rx_valid=1; tx_ready=1 after CS fall.
- Parametrise CPOL/CPHA over all 4 modes with WIDTH=16 and word 16'hBEEF both directions -> rx_data=16'hBEEF and master captures 16'hBEEF in every mode.
- MSB_FIRST=0, WIDTH=8, master sends bit stream 1,1,0,0,0,1,0,1 -> rx_data=8'hA3.
- Two back-to-back words in one CS (8'h12, 8'h34) with rx_ready tied low and the holding register empty for the second word -> first rx_data=8'h12 retained; overrun pulses once; underrun pulses once at the second word; second word transmitted as 8'h00.
- CS deasserted after 5 bits -> no rx_valid, no overrun, busy=0 and miso_oe=0 within SYNC_STAGES+1 cycles; the next full frame receives correctly.
- rst pulsed after bit 3 of a frame -> all outputs at reset values immediately; CS low held after release does not start a frame; CS rising then falling starts a clean frame.
